nibble_serial_addsub: RTL and testbench
=======================================

NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit digits per operand (range 2..8).
REQ-002 CLOCK  input  1  single system clock (10 MHz board clock), all state on rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 M  input  1  operation select: 0 = add X+Y, 1 = subtract X-Y.
REQ-006 X  input  4*NIBBLES  first operand, two's complement.
REQ-007 Y  input  4*NIBBLES  second operand, two's complement.
REQ-008 BUSY  output  1  high while an operation is in progress (RUN or FIN).
REQ-009 DONE  output  1  one-cycle pulse when results become valid.
REQ-010 F  output  4*NIBBLES  result register.
REQ-011 FLAGS  output  4  {SIGN, ZERO, OVERFLOW, CARRYOUT} registered status.

Function
REQ-012 States IDLE, RUN, FIN; a single 4-bit add/sub unit is reused once per nibble, LSB nibble first.
REQ-013 IDLE & START=1: latch X, Y, M into operand registers; carry register <= M; nibble index <= 0; go to RUN.
REQ-014 IDLE & START=0: remain in IDLE; F and FLAGS hold.
REQ-015 RUN, each cycle: A = X nibble[idx], B = Y nibble[idx] XOR {4{M}}, Cin = carry register; {C4,S} = A+B+Cin; write S into F nibble[idx]; carry <= C4; idx <= idx+1.
REQ-016 RUN with idx = NIBBLES-1: additionally capture OVERFLOW = (~A3&~B3&S3)|(A3&B3&~S3) of that nibble and the final C4; go to FIN.
REQ-017 FIN: compute SIGN = F MSB, ZERO = (F == 0), CARRYOUT = C4 if M=0 else ~C4 (borrow); update FLAGS; assert DONE for exactly this cycle; go to IDLE.
REQ-018 Latency: START accepted at edge k; DONE high in cycle k+NIBBLES+1; next START accepted in the cycle after DONE.
REQ-019 BUSY high from the cycle after START acceptance through the DONE cycle inclusive.
REQ-020 START while BUSY is ignored; X, Y, M changes while BUSY do not affect the result.
REQ-021 F nibbles update progressively during RUN; F and FLAGS are valid only from the DONE cycle and hold until the next completed FIN.
REQ-022 FLAGS are not modified during RUN; they retain previous operation's values.
REQ-023 All arithmetic is modulo 2^(4*NIBBLES); carry out of the top nibble is not added to F.

Reset
REQ-024 RESET_N low asynchronously forces state IDLE, idx 0, carry 0, F 0, FLAGS 4'b0000, BUSY 0, DONE 0, operand registers 0.
REQ-025 Reset during RUN or FIN aborts the operation; no DONE pulse is produced; first START after release is accepted normally.

Structure
REQ-026 Package nibble_addsub_pkg holds state enum (IDLE, RUN, FIN), op constants OP_ADD=0/OP_SUB=1, and the flag bit-index constants.
REQ-027 Sub-module addsub4: combinational 4-bit A+B+Cin with C4, S and nibble overflow outputs; instantiated once.
REQ-028 Controller, operand/result registers and flag logic reside in nibble_serial_addsub; no other sub-modules.

Verification (NIBBLES=4)
REQ-029 M=0, X=0x1234, Y=0x0FFF, START pulse -> DONE 5 cycles later, F=0x2233, FLAGS=0000.
REQ-030 M=1, X=0x0000, Y=0x0001 -> F=0xFFFF, SIGN=1, ZERO=0, OVERFLOW=0, CARRYOUT=1 (borrow).
REQ-031 M=0, X=0x7FFF, Y=0x0001 -> F=0x8000, OVERFLOW=1, SIGN=1; M=1, X=0x8000, Y=0x0001 -> F=0x7FFF, OVERFLOW=1, CARRYOUT=0.
REQ-032 M=1, X=0x1234, Y=0x1234 -> F=0x0000, ZERO=1, CARRYOUT=0, OVERFLOW=0.
REQ-033 START re-pulsed and X changed to 0xFFFF during RUN of 0x1111+0x2222 -> ignored, F=0x3333, single DONE pulse.
REQ-034 RESET_N low during RUN cycle 2 -> BUSY, DONE, F, FLAGS read 0 immediately; no DONE pulse; subsequent 0x0001+0x0001 yields F=0x0002.

Source files
------------

// File: rtl/nibble_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
//   state_t   : controller states
//   OP_ADD/OP_SUB : values of the operation-select input
//   FLAG_*    : bit positions inside the 4-bit status word
package nibble_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int FLAG_SIGN  = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_CARRY = 0;

endpackage

// File: rtl/addsub4.sv
// Combinational 4-bit adder slice reused once per nibble.
// The caller pre-inverts b for subtraction and supplies the carry-in.
//   a, b : 4-bit operands
//   cin  : carry in
//   s    : 4-bit sum
//   c4   : carry out of bit 3
//   ovf  : signed overflow of this nibble, treated as the top nibble
module addsub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c4,
    output logic       ovf
);

    always_comb begin
        {c4, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        ovf     = (~a[3] & ~b[3] & s[3]) | (a[3] & b[3] & ~s[3]);
    end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial two's complement adder/subtractor.
// One addsub4 slice processes one nibble per cycle, LSB nibble first.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   start   : begin an operation (sampled only in IDLE)
//   m       : 0 = x + y, 1 = x - y
//   x, y    : operands, 4*NIBBLES bits
//   busy    : operation in progress (RUN or FIN)
//   done    : one-cycle pulse, f and flags valid
//   f       : result register
//   flags   : {sign, zero, overflow, carry/borrow}
//
// state | meaning
// IDLE  | waiting for start, f and flags hold
// RUN   | one nibble added per cycle
// FIN   | result complete, done pulse
module nibble_serial_addsub
    import nibble_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   m,
    input  logic [4*NIBBLES-1:0]   x,
    input  logic [4*NIBBLES-1:0]   y,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   f,
    output logic [3:0]             flags
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [W-1:0]       x_reg;
    logic [W-1:0]       y_reg;
    logic               m_reg;

    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [3:0]         sum;
    logic               c4;
    logic               ovf;
    logic               last;
    logic [W-1:0]       f_next;
    logic [3:0]         flags_next;

    always_comb begin
        a_nib = x_reg[4*idx +: 4];
        b_nib = (m_reg == OP_ADD) ? y_reg[4*idx +: 4] : ~y_reg[4*idx +: 4];
        last  = (idx == IDX_W'(NIBBLES - 1));
    end

    addsub4 u_addsub4 (
        .a   (a_nib),
        .b   (b_nib),
        .cin (carry),
        .s   (sum),
        .c4  (c4),
        .ovf (ovf)
    );

    always_comb begin
        f_next = f;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                f_next[4*i +: 4] = sum;
            end
        end
    end

    // Status is built from the result as it will stand after the last
    // nibble write, so flags are already valid in the FIN (done) cycle.
    always_comb begin
        flags_next             = 4'b0000;
        flags_next[FLAG_SIGN]  = f_next[W-1];
        flags_next[FLAG_ZERO]  = (f_next == '0);
        flags_next[FLAG_OVF]   = ovf;
        flags_next[FLAG_CARRY] = (m_reg == OP_ADD) ? c4 : ~c4;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            carry <= 1'b0;
            x_reg <= '0;
            y_reg <= '0;
            m_reg <= 1'b0;
            f     <= '0;
            flags <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_reg <= x;
                        y_reg <= y;
                        m_reg <= m;
                        carry <= m;   // +1 of the two's complement negate
                        idx   <= '0;
                    end
                end
                RUN: begin
                    f     <= f_next;
                    carry <= c4;
                    if (last) begin
                        idx   <= '0;
                        flags <= flags_next;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
module tb_nibble_serial_addsub;

    typedef struct packed {
        logic [15:0] f;
        logic [3:0]  flags;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        m;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [15:0] f;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    nibble_serial_addsub #(.NIBBLES(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .m       (m),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .f       (f),
        .flags   (flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Reference: plain 16-bit arithmetic, flags {sign, zero, ovf, carry/borrow}
    function automatic exp_t model(input logic [15:0] xv, input logic [15:0] yv, input logic mv);
        logic [16:0] full;
        logic [15:0] r;
        logic        ov;
        logic        co;
        if (!mv) begin
            full = {1'b0, xv} + {1'b0, yv};
            r    = full[15:0];
            ov   = (xv[15] == yv[15]) && (r[15] != xv[15]);
            co   = full[16];
        end else begin
            r  = xv - yv;
            ov = (xv[15] != yv[15]) && (r[15] != xv[15]);
            co = (xv < yv);
        end
        return {r, r[15], (r == 16'h0000), ov, co};
    endfunction

    task automatic issue(input logic [15:0] xv, input logic [15:0] yv, input logic mv, input exp_t e);
        @(posedge clock); #1;
        x = xv; y = yv; m = mv; start = 1'b1;
        exp_q.push_back(e);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Waits for done; lat is the expected number of negedges from the call.
    task automatic wait_done(input string name, input int lat);
        int   n;
        bit   seen;
        exp_t e;
        n = 0;
        seen = 0;
        while (n < 20 && !seen) begin
            @(negedge clock);
            n++;
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout: no done within %0d cycles", name, n);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, lat);
        end
        e = exp_q.pop_front();
        checks++;
        if (f !== e.f) begin
            errors++;
            $display("FAIL %s f: got %h, expected %h", name, f, e.f);
        end
        checks++;
        if (flags !== e.flags) begin
            errors++;
            $display("FAIL %s flags: got %b, expected %b", name, flags, e.flags);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b, expected 1", name, busy);
        end
    endtask

    task automatic check_done_low(input string name);
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b, expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; m = 1'b0; x = '0; y = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, f, flags} !== 22'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b f=%h flags=%b, expected all 0", busy, done, f, flags);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        issue(16'h1234, 16'h0FFF, 1'b0, {16'h2233, 4'b0000});
        checks++;
        @(negedge clock);
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL add busy_after_start: got %b, expected 1", busy);
        end
        wait_done("add", 4);
        check_done_low("add");
    endtask

    task automatic test_sub_borrow();
        issue(16'h0000, 16'h0001, 1'b1, {16'hFFFF, 4'b1001});
        wait_done("sub_borrow", 5);
        check_done_low("sub_borrow");
    endtask

    task automatic test_overflow();
        issue(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 4'b1010});
        wait_done("add_ovf", 5);
        check_done_low("add_ovf");
        issue(16'h8000, 16'h0001, 1'b1, {16'h7FFF, 4'b0010});
        wait_done("sub_ovf", 5);
        check_done_low("sub_ovf");
    endtask

    task automatic test_zero();
        issue(16'h1234, 16'h1234, 1'b1, {16'h0000, 4'b0100});
        wait_done("zero", 5);
        check_done_low("zero");
    endtask

    task automatic test_reset_abort();
        int pulses;
        issue(16'h1234, 16'h1111, 1'b0, {16'h2345, 4'b0000});
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, f, flags} !== 22'h0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b done=%b f=%h flags=%b, expected all 0", busy, done, f, flags);
        end
        void'(exp_q.pop_front());
        pulses = 0;
        repeat (3) begin
            @(negedge clock);
            if (done === 1'b1) pulses++;
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, expected 0", pulses);
        end
        issue(16'h0001, 16'h0001, 1'b0, {16'h0002, 4'b0000});
        wait_done("after_abort", 5);
        check_done_low("after_abort");
    endtask

    task automatic test_busy_ignore();
        int pulses;
        issue(16'h1111, 16'h2222, 1'b0, {16'h3333, 4'b0000});
        @(negedge clock);
        start = 1'b1; x = 16'hFFFF; y = 16'h0000; m = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("busy_ignore", 3);
        pulses = 0;
        repeat (8) begin
            @(negedge clock);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL busy_ignore extra_done: got %0d pulses, expected 0", pulses);
        end
        checks++;
        if (f !== 16'h3333 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL idle_hold: got f=%h flags=%b, expected 3333 0000", f, flags);
        end
    endtask

    // start held high from the done cycle: ignored in FIN, accepted in the next cycle
    task automatic test_back_to_back();
        issue(16'h00FF, 16'h0001, 1'b0, model(16'h00FF, 16'h0001, 1'b0));
        wait_done("b2b_first", 5);
        x = 16'h8000; y = 16'h8000; m = 1'b0; start = 1'b1;
        exp_q.push_back(model(16'h8000, 16'h8000, 1'b0));
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b single_pulse: got done=%b, expected 0", done);
        end
        @(posedge clock); #1;
        start = 1'b0;
        wait_done("b2b_second", 5);
        check_done_low("b2b_second");
    endtask

    task automatic test_random();
        logic [15:0] xv;
        logic [15:0] yv;
        logic        mv;
        for (int i = 0; i < 6; i++) begin
            xv = 16'($urandom);
            yv = 16'($urandom);
            mv = 1'($urandom_range(1, 0));
            issue(xv, yv, mv, model(xv, yv, mv));
            wait_done("random", 5);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_borrow();
        test_overflow();
        test_zero();
        test_reset_abort();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
